// File: rtl/decode_bypass.sv
// Beta decode stage: IR/PC register, operand bypass, load-use interlock, branch resolve, exception inject.
// Latency: one cycle from decode to the EX register. stall, branch_taken, target and exc_taken are combinational.
// Backpressure: stall holds IR/PC and sends a NOP into EX. kill squashes the wrong-path fetch for one cycle.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pc_plus_four, inst           fetch PC+4 and fetched instruction
//   irq                          level exception request
//   rf_ra1/2, rf_rd1/2           register file read address out, read data in
//   {ex,mem,wb}_{rc,wen,bypass}  downstream destination, write enable and forwarded value
//   ex_is_ld, mem_is_ld          stage holds LD/LDR, so its bypass value is not the load data
//   stall, branch_taken, target  fetch control
//   exc_taken                    redirect fetch to XAdr
//   ex_pc/a/b/st_data/inst       registered EX operands
module decode_bypass #(
    parameter int          XLEN      = 32,
    parameter bit          BYPASS_EN = 1'b1,
    parameter logic [31:0] NOP_INST  = 32'h83FFF800,
    parameter logic [31:0] EXC_INST  = 32'h77DF0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_plus_four,
    input  logic [31:0]     inst,
    input  logic            irq,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic [4:0]      ex_rc,
    input  logic [4:0]      mem_rc,
    input  logic [4:0]      wb_rc,
    input  logic            ex_wen,
    input  logic            mem_wen,
    input  logic            wb_wen,
    input  logic            ex_is_ld,
    input  logic            mem_is_ld,
    input  logic [XLEN-1:0] ex_bypass,
    input  logic [XLEN-1:0] mem_bypass,
    input  logic [XLEN-1:0] wb_bypass,
    output logic            stall,
    output logic            branch_taken,
    output logic [XLEN-1:0] target,
    output logic            exc_taken,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_st_data,
    output logic [31:0]     ex_inst
);

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;

    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] ex_pc_d, ex_a_d, ex_b_d, ex_st_d;
    logic [31:0]     ex_inst_d;

    // A squashed slot decodes as a NOP, which only reads R31 and so raises no hazard.
    logic [31:0] ir_eff;
    assign ir_eff = kill_q ? NOP_INST : ir_q;

    logic [5:0]  opcode;
    logic [4:0]  rc, ra, rb;
    logic [15:0] c_fld;
    assign opcode = ir_eff[31:26];
    assign rc     = ir_eff[25:21];
    assign ra     = ir_eff[20:16];
    assign rb     = ir_eff[15:11];
    assign c_fld  = ir_eff[15:0];

    logic is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr, is_op, is_opc;
    assign is_ld  = (opcode == OP_LD);
    assign is_st  = (opcode == OP_ST);
    assign is_jmp = (opcode == OP_JMP);
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_ldr = (opcode == OP_LDR);
    assign is_op  = (opcode[5:4] == 2'b10);
    assign is_opc = (opcode[5:4] == 2'b11);

    assign rf_ra1 = ra;
    assign rf_ra2 = is_st ? rc : rb;

    logic use1, use2;
    assign use1 = !is_ldr;
    assign use2 = is_op | is_st;

    function automatic logic hit(input logic [4:0] a, input logic [4:0] src, input logic wen);
        return wen && (a == src) && (a != 5'd31);
    endfunction

    logic hit_ex1, hit_mem1, hit_wb1, hit_ex2, hit_mem2, hit_wb2;
    assign hit_ex1  = hit(rf_ra1, ex_rc,  ex_wen);
    assign hit_mem1 = hit(rf_ra1, mem_rc, mem_wen);
    assign hit_wb1  = hit(rf_ra1, wb_rc,  wb_wen);
    assign hit_ex2  = hit(rf_ra2, ex_rc,  ex_wen);
    assign hit_mem2 = hit(rf_ra2, mem_rc, mem_wen);
    assign hit_wb2  = hit(rf_ra2, wb_rc,  wb_wen);

    // Youngest producer wins: EX over MEM over WB over the register file.
    logic [XLEN-1:0] d1, d2;
    always_comb begin
        d1 = rf_rd1;
        if (rf_ra1 == 5'd31) d1 = '0;
        else if (hit_ex1)    d1 = ex_bypass;
        else if (hit_mem1)   d1 = mem_bypass;
        else if (hit_wb1)    d1 = wb_bypass;
        d2 = rf_rd2;
        if (rf_ra2 == 5'd31) d2 = '0;
        else if (hit_ex2)    d2 = ex_bypass;
        else if (hit_mem2)   d2 = mem_bypass;
        else if (hit_wb2)    d2 = wb_bypass;
    end

    logic ld_haz, raw_haz;
    assign ld_haz  = (use1 && ((hit_ex1 && ex_is_ld) || (hit_mem1 && mem_is_ld))) ||
                     (use2 && ((hit_ex2 && ex_is_ld) || (hit_mem2 && mem_is_ld)));
    assign raw_haz = (use1 && (hit_ex1 || hit_mem1 || hit_wb1)) ||
                     (use2 && (hit_ex2 || hit_mem2 || hit_wb2));
    assign stall   = ld_haz || (!BYPASS_EN && raw_haz);

    logic [XLEN-1:0] sxt_c, branch_addr, jump_addr;
    logic            zero;
    assign sxt_c       = {{(XLEN-16){c_fld[15]}}, c_fld};
    assign branch_addr = pc_q + {sxt_c[XLEN-3:0], 2'b00};
    assign jump_addr   = {d1[XLEN-1:2], 2'b00};
    assign zero        = (d1 == '0);

    // Exceptions are only taken on a real, non-squashed instruction that is free to advance.
    assign exc_taken    = irq && !stall && !kill_q && (ir_q != NOP_INST);
    assign branch_taken = !stall && !kill_q && !exc_taken &&
                          (is_jmp || (is_beq && zero) || (is_bne && !zero));
    assign target       = is_jmp ? jump_addr : branch_addr;

    always_comb begin
        ir_d      = stall ? ir_q : inst;
        pc_d      = stall ? pc_q : pc_plus_four;
        kill_d    = branch_taken || exc_taken;
        ex_pc_d   = pc_q;
        ex_inst_d = ir_eff;
        ex_a_d    = is_ldr ? branch_addr : d1;
        ex_b_d    = (is_ld || is_st || is_opc) ? sxt_c : d2;
        ex_st_d   = d2;
        if (stall || kill_q) begin
            ex_inst_d = NOP_INST;
            ex_a_d    = '0;
            ex_b_d    = '0;
            ex_st_d   = '0;
        end else if (exc_taken) begin
            // ex_pc carries this instruction's PC+4, which the injected BNE writes into XP.
            ex_inst_d = EXC_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= NOP_INST;
            pc_q       <= '0;
            kill_q     <= 1'b0;
            ex_pc      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_st_data <= '0;
            ex_inst    <= NOP_INST;
        end else begin
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            ex_pc      <= ex_pc_d;
            ex_a       <= ex_a_d;
            ex_b       <= ex_b_d;
            ex_st_data <= ex_st_d;
            ex_inst    <= ex_inst_d;
        end
    end

endmodule

// File: tb/tb_decode_bypass.sv
// Testbench for decode_bypass: two instances (bypass on / bypass off) against a behavioural model.
// Latency: comb outputs sampled mid-cycle, EX register sampled just after the edge.
// Backpressure: model tracks its own IR/PC/kill and holds on its own predicted stall.
module tb_decode_bypass;

    localparam logic [31:0] NOP = 32'h83FFF800;
    localparam logic [31:0] EXC = 32'h77DF0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_plus_four, inst;
    logic        irq;
    logic [4:0]  s_rc  [3];
    logic        s_wen [3];
    logic        s_ld  [2];
    logic [31:0] s_byp [3];
    logic [31:0] regs  [32];

    logic [4:0]  ra1_w [2], ra2_w [2];
    logic [31:0] rd1_w [2], rd2_w [2];
    logic        stall_w [2], bt_w [2], exc_w [2];
    logic [31:0] tgt_w [2], expc_w [2], exa_w [2], exb_w [2], exst_w [2], exinst_w [2];

    always #5 clk = ~clk;

    assign rd1_w[0] = regs[ra1_w[0]];
    assign rd2_w[0] = regs[ra2_w[0]];
    assign rd1_w[1] = regs[ra1_w[1]];
    assign rd2_w[1] = regs[ra2_w[1]];

    decode_bypass #(.XLEN(32), .BYPASS_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .pc_plus_four(pc_plus_four), .inst(inst), .irq(irq),
        .rf_ra1(ra1_w[0]), .rf_ra2(ra2_w[0]), .rf_rd1(rd1_w[0]), .rf_rd2(rd2_w[0]),
        .ex_rc(s_rc[0]), .mem_rc(s_rc[1]), .wb_rc(s_rc[2]),
        .ex_wen(s_wen[0]), .mem_wen(s_wen[1]), .wb_wen(s_wen[2]),
        .ex_is_ld(s_ld[0]), .mem_is_ld(s_ld[1]),
        .ex_bypass(s_byp[0]), .mem_bypass(s_byp[1]), .wb_bypass(s_byp[2]),
        .stall(stall_w[0]), .branch_taken(bt_w[0]), .target(tgt_w[0]), .exc_taken(exc_w[0]),
        .ex_pc(expc_w[0]), .ex_a(exa_w[0]), .ex_b(exb_w[0]), .ex_st_data(exst_w[0]),
        .ex_inst(exinst_w[0])
    );

    decode_bypass #(.XLEN(32), .BYPASS_EN(1'b0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .pc_plus_four(pc_plus_four), .inst(inst), .irq(irq),
        .rf_ra1(ra1_w[1]), .rf_ra2(ra2_w[1]), .rf_rd1(rd1_w[1]), .rf_rd2(rd2_w[1]),
        .ex_rc(s_rc[0]), .mem_rc(s_rc[1]), .wb_rc(s_rc[2]),
        .ex_wen(s_wen[0]), .mem_wen(s_wen[1]), .wb_wen(s_wen[2]),
        .ex_is_ld(s_ld[0]), .mem_is_ld(s_ld[1]),
        .ex_bypass(s_byp[0]), .mem_bypass(s_byp[1]), .wb_bypass(s_byp[2]),
        .stall(stall_w[1]), .branch_taken(bt_w[1]), .target(tgt_w[1]), .exc_taken(exc_w[1]),
        .ex_pc(expc_w[1]), .ex_a(exa_w[1]), .ex_b(exb_w[1]), .ex_st_data(exst_w[1]),
        .ex_inst(exinst_w[1])
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state per instance (0 = bypass on, 1 = bypass off).
    logic [31:0] m_ir [2], m_pc [2];
    logic        m_kill [2];
    logic        e_stall [2], e_bt [2], e_exc [2];
    logic [31:0] e_tgt [2], e_inst [2], e_a [2], e_b [2], e_st [2];
    logic [4:0]  e_ra1 [2], e_ra2 [2];

    function automatic logic [31:0] read_val(input logic [4:0] a);
        if (a == 5'd31) return 32'd0;
        for (int k = 0; k < 3; k++)
            if (s_wen[k] && s_rc[k] == a) return s_byp[k];
        return regs[a];
    endfunction

    task automatic model_eval(input int i);
        logic [31:0] w, d1, d2, sc, baddr;
        logic [5:0]  op;
        logic [4:0]  addr [2];
        logic        used [2];
        logic        haz, ld, st, jmp, beq, bne, ldr, opr, opc;
        w    = m_kill[i] ? NOP : m_ir[i];
        op   = w[31:26];
        ld   = (op == 6'o30); st  = (op == 6'o31); jmp = (op == 6'o33);
        beq  = (op == 6'o34); bne = (op == 6'o35); ldr = (op == 6'o37);
        opr  = (op >= 6'o40 && op < 6'o60);
        opc  = (op >= 6'o60);
        addr[0] = w[20:16];
        addr[1] = st ? w[25:21] : w[15:11];
        used[0] = !ldr;
        used[1] = opr || st;
        haz = 1'b0;
        for (int p = 0; p < 2; p++)
            if (used[p] && addr[p] != 5'd31)
                for (int k = 0; k < 3; k++)
                    if (s_wen[k] && s_rc[k] == addr[p]) begin
                        if (i == 1) haz = 1'b1;
                        if (k < 2 && s_ld[k]) haz = 1'b1;
                    end
        d1    = read_val(addr[0]);
        d2    = read_val(addr[1]);
        sc    = {{16{w[15]}}, w[15:0]};
        baddr = m_pc[i] + sc * 32'd4;
        e_ra1[i]   = addr[0];
        e_ra2[i]   = addr[1];
        e_stall[i] = haz;
        e_exc[i]   = irq && !haz && !m_kill[i] && m_ir[i] != NOP;
        e_bt[i]    = !haz && !m_kill[i] && !e_exc[i] &&
                     (jmp || (beq && d1 == 0) || (bne && d1 != 0));
        e_tgt[i]   = jmp ? (d1 & ~32'd3) : baddr;
        e_inst[i]  = (haz || m_kill[i]) ? NOP : (e_exc[i] ? EXC : w);
        e_a[i]     = (haz || m_kill[i]) ? 32'd0 : (ldr ? baddr : d1);
        e_b[i]     = (haz || m_kill[i]) ? 32'd0 : ((ld || st || opc) ? sc : d2);
        e_st[i]    = (haz || m_kill[i]) ? 32'd0 : d2;
    endtask

    // Mid-cycle: evaluate the model and compare combinational outputs.
    task automatic step_comb();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_eval(i);
            check($sformatf("ra1[%0d]", i),   {27'd0, ra1_w[i]}, {27'd0, e_ra1[i]});
            check($sformatf("ra2[%0d]", i),   {27'd0, ra2_w[i]}, {27'd0, e_ra2[i]});
            check($sformatf("stall[%0d]", i), {31'd0, stall_w[i]}, {31'd0, e_stall[i]});
            check($sformatf("exc[%0d]", i),   {31'd0, exc_w[i]}, {31'd0, e_exc[i]});
            check($sformatf("bt[%0d]", i),    {31'd0, bt_w[i]}, {31'd0, e_bt[i]});
            check($sformatf("tgt[%0d]", i),   tgt_w[i], e_tgt[i]);
        end
    endtask

    // Just after the edge: compare the EX register and advance the model.
    task automatic step_seq();
        logic [31:0] pc_old [2];
        logic        exc_old [2];
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            pc_old[i]  = m_pc[i];
            exc_old[i] = e_exc[i];
            if (rst) begin
                m_ir[i] = NOP; m_pc[i] = 0; m_kill[i] = 1'b0;
                pc_old[i] = 0; exc_old[i] = 1'b0;
                e_inst[i] = NOP; e_a[i] = 0; e_b[i] = 0; e_st[i] = 0;
            end else begin
                if (!e_stall[i]) begin
                    m_ir[i] = inst;
                    m_pc[i] = pc_plus_four;
                end
                m_kill[i] = e_bt[i] || e_exc[i];
            end
            check($sformatf("ex_pc[%0d]", i),   expc_w[i], pc_old[i]);
            check($sformatf("ex_inst[%0d]", i), exinst_w[i], e_inst[i]);
            if (!exc_old[i]) begin
                check($sformatf("ex_a[%0d]", i),  exa_w[i],  e_a[i]);
                check($sformatf("ex_b[%0d]", i),  exb_w[i],  e_b[i]);
                check($sformatf("ex_st[%0d]", i), exst_w[i], e_st[i]);
            end
        end
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] rand_val();
        return ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        case ($urandom_range(0, 9))
            0: op = 6'o30;  1: op = 6'o31;  2: op = 6'o33;  3: op = 6'o34;
            4: op = 6'o35;  5: op = 6'o37;
            6: op = {2'b10, 4'($urandom)};
            7: op = {2'b11, 4'($urandom)};
            8: return NOP;
            default: op = 6'($urandom);
        endcase
        return {op, pick_reg(), pick_reg(), pick_reg(), 11'($urandom)};
    endfunction

    task automatic quiet_stages();
        for (int k = 0; k < 3; k++) begin
            s_rc[k] = 5'd0; s_wen[k] = 1'b0; s_byp[k] = 32'd0;
        end
        s_ld[0] = 1'b0; s_ld[1] = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        quiet_stages();
        rst = 1'b1; irq = 1'b0; inst = 32'h0; pc_plus_four = 32'h0;
        m_ir[0] = 32'hx; m_ir[1] = 32'hx; m_pc[0] = 0; m_pc[1] = 0;
        m_kill[0] = 1'b0; m_kill[1] = 1'b0;
        #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ir[0] = NOP; m_ir[1] = NOP;
        step_comb();
        step_seq();
        check("rst_ex_inst", exinst_w[0], NOP);
        check("rst_ex_pc",   expc_w[0], 32'd0);
        rst = 1'b0;
        step_comb();
        check("rst_stall", {31'd0, stall_w[0]}, 32'd0);
        check("rst_exc",   {31'd0, exc_w[0]}, 32'd0);

        // Directed: BEQ(R2,-2) at pc_decode 0x104, then JMP(R4 = 0x203).
        regs[2] = 32'd0; regs[4] = 32'h203;
        inst = {6'o34, 5'd31, 5'd2, 16'hFFFE}; pc_plus_four = 32'h104;
        step_seq();
        inst = {6'o33, 5'd31, 5'd4, 16'h0}; pc_plus_four = 32'h108;
        step_comb();
        check("dir_beq_bt",  {31'd0, bt_w[0]}, 32'd1);
        check("dir_beq_tgt", tgt_w[0], 32'hFC);
        step_seq();
        step_comb();
        check("dir_kill_bt", {31'd0, bt_w[0]}, 32'd0);
        step_seq();
        check("dir_kill_nop", exinst_w[0], NOP);
        inst = {6'b100000, 5'd1, 5'd2, 5'd3, 11'd0}; pc_plus_four = 32'h40;
        step_comb();
        check("dir_jmp_tgt", tgt_w[0], 32'h200);
        step_seq();
        step_comb();
        step_seq();
        irq = 1'b1;
        step_comb();
        check("dir_exc", {31'd0, exc_w[0]}, 32'd1);
        step_seq();
        check("dir_exc_inst", exinst_w[0], EXC);
        check("dir_exc_pc",   expc_w[0], 32'h40);
        irq = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            inst         = rand_inst();
            pc_plus_four = {$urandom, 2'b00} >> 0;
            pc_plus_four[1:0] = 2'b00;
            irq          = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 3; k++) begin
                s_rc[k]  = pick_reg();
                s_wen[k] = $urandom_range(0, 1) == 1;
                s_byp[k] = rand_val();
            end
            s_ld[0] = ($urandom_range(0, 3) == 0);
            s_ld[1] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 5)] = rand_val();
            if ($urandom_range(0, 15) == 0) regs[31] = $urandom;
            step_comb();
            step_seq();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_bypass.md
# decode_bypass

Parametrised Beta decode stage with full operand bypassing, load-use interlock, in-decode branch resolution and exception injection. It sits between fetch and execute. It holds the IR/PC pipeline register and drives the register-file read ports, and it registers the resolved operands into the EX pipeline register. Hazards that bypassing cannot cover are stalled rather than left unhandled.

## Interface
- XLEN, 32: datapath width (≥32); instructions remain 32 bits.
- BYPASS_EN, 1: 1 = forward from EX/MEM/WB; 0 = stall on any RAW hazard.
- NOP_INST, 32'h83FFF800: ADD(R31,R31,R31).
- EXC_INST, 32'h77DF0000: BNE(R31,0,XP), injected on exception.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_plus_four  in  XLEN  fetch PC+4
- inst  in  32  fetched instruction
- irq  in  1  exception request, level
- rf_ra1, rf_ra2  out  5  register file read addresses
- rf_rd1, rf_rd2  in  XLEN  register file read data, combinational
- ex_rc, mem_rc, wb_rc  in  5  destination register of each downstream stage
- ex_wen, mem_wen, wb_wen  in  1  the stage writes its rc
- ex_is_ld, mem_is_ld  in  1  the stage holds LD/LDR; its bypass value is not the load data
- ex_bypass, mem_bypass, wb_bypass  in  XLEN  forwarded results
- stall  out  1  hold fetch; combinational
- branch_taken  out  1  redirect fetch to target (BEQ/BNE taken, JMP)
- target  out  XLEN  branch_addr or jump_addr
- exc_taken  out  1  redirect fetch to XAdr
- ex_pc, ex_a, ex_b, ex_st_data  out  XLEN  registered EX operands
- ex_inst  out  32  registered EX instruction

## Operation
- Fields: opcode = ir[31:26], rc = ir[25:21], ra = ir[20:16], rb = ir[15:11], C = ir[15:0].
- Class decode:
  - LD = 011000, ST = 011001, JMP = 011011, BEQ = 011100, BNE = 011101, LDR = 011111.
  - OP = 10xxxx; OPC = 11xxxx.
- Read ports: rf_ra1 = ra; rf_ra2 = ST ? rc : rb.
- Read-port usage:
  - Port 1 is used by all classes except LDR.
  - Port 2 is used by OP and ST only.
- Bypass per port:
  - Register 31 always reads 0 and never matches a bypass source.
  - Otherwise the value is the first match in order EX, MEM, WB (rc equal and wen set), else rf_rdN.
- Load-use stall: raised when a used port matches EX with ex_is_ld, or MEM with mem_is_ld.
- BYPASS_EN = 0: stall on any used-port match against EX, MEM or WB.
- Computed values (SXT = sign extension to XLEN):
  - d1 = bypassed port 1 value; d2 = bypassed port 2 value.
  - branch_addr = pc_decode + (SXT(C) << 2), where pc_decode already holds PC+4.
  - jump_addr = d1 with bits [1:0] cleared.
  - zero = (d1 == 0).
- EX operands:
  - ex_a = LDR ? branch_addr : d1.
  - ex_b = (LD | ST | OPC) ? SXT(C) : d2.
  - ex_st_data = d2.
- branch_taken = !stall & !kill & (JMP | BEQ&zero | BNE&!zero); target = JMP ? jump_addr : branch_addr.
- Exception:
  - exc_taken = irq & !stall & !kill & IR ≠ NOP_INST.
  - Priority: exception > branch; branch_taken is forced 0 when exc_taken.
- kill flag: set for one cycle after branch_taken or exc_taken. While set, the IR content is treated as NOP_INST (the wrong-path fetch is squashed).

## Timing
- Operand, bypass, stall, branch and exception logic is combinational.
- IR/PC register: on posedge, if !stall, ir ← inst and pc_decode ← pc_plus_four; otherwise both hold.
- EX register: loaded every cycle, with ex_pc = pc_decode and ex_inst selected as:
  - stall or kill: ex_inst = NOP_INST, with ex_a/ex_b/ex_st_data = 0.
  - exc_taken: ex_inst = EXC_INST, so XP receives the interrupted instruction's PC+4.
  - otherwise: ex_inst = ir.
- Decode-to-EX latency: 1 cycle.
- Load-use stall length: 2 cycles with the load in EX, 1 cycle with it in MEM.
- Reset values:
  - ir = ex_inst = NOP_INST.
  - pc_decode = ex_pc = ex_a = ex_b = ex_st_data = 0.
  - kill = 0.
  - stall, branch_taken and exc_taken evaluate 0.
- A reset mid-stall or mid-kill clears all state the same cycle.
- Simultaneous stall and irq: the exception is deferred until the stall clears.

## Test plan
- Bypass priority: ADD R1 in EX (5), MEM (6) and WB (7) simultaneously; decode ADD(R1,R1,R2) -> ex_a = 5, no stall; repeat with only WB writing -> 7.
- R31 guard: EX writes R31 = 9; decode reads R31 -> ex_a = 0, stall = 0.
- Load-use: LD R3 in EX; decode ADD(R3,R4,R5) -> stall for 2 cycles, 2 NOPs into EX, IR/PC held; 3rd cycle ex_a = wb_bypass.
- Branch: pc_decode = 0x104, BEQ(R2,-2) with R2 = 0 -> branch_taken, target = 0xFC; next IR issues NOP_INST to EX. JMP R4 = 0x203 -> target = 0x200.
- Exception: irq with ADD in IR at pc_decode = 0x40 -> exc_taken, ex_inst = 0x77DF0000, ex_pc = 0x40; irq during stall -> deferred.
- BYPASS_EN = 0: MEM writes R1; decode reads R1 -> stall until the writer leaves WB.
